// File: rtl/serial_word_pkg.sv
// Shared definitions for the serial word transmitter and its shift-register-side checker.
package serial_word_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: pulses tick on the last clock of every DIV-clock bit period.
module bit_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  // Count 0..DIV-1; a tick or a restart begins a fresh bit period at zero.
  always_ff @(posedge clk) begin
    if (!clr || restart || tick) r_cnt <= '0;
    else                         r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/serial_word_tx.sv
// Serializes a parallel word, LSB first, as start / data / optional even parity / stop,
// holding each bit level for DIV clocks.
module serial_word_tx
  import serial_word_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             s_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int            BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_par;
  logic [BW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] w_shift;
  logic             w_tick;
  logic             w_accept;

  // The divider is held at zero while idle so the start bit gets a full period.
  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .clr     (clr),
    .restart (r_state == IDLE),
    .tick    (w_tick)
  );

  assign din_ready = clr && (r_state == IDLE);
  assign w_accept  = din_valid && din_ready;
  assign w_shift   = r_shreg >> 1;

  // Frame sequencer: line level, busy and frame_done are all registered here.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state    <= IDLE;
      r_bitcnt   <= '0;
      s_out      <= LINE_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          s_out <= LINE_IDLE;
          if (w_accept) begin
            r_shreg  <= din;
            r_par    <= ^din;
            r_bitcnt <= '0;
            r_state  <= START;
            s_out    <= START_LVL;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            s_out   <= r_shreg[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bitcnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                r_state <= PARITY;
                s_out   <= r_par;
              end else begin
                r_state <= STOP;
                s_out   <= STOP_LVL;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
              r_shreg  <= w_shift;
              s_out    <= w_shift[0];
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            s_out   <= STOP_LVL;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state    <= IDLE;
            s_out      <= LINE_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          s_out   <= LINE_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: three instances cover DIV=1 with parity,
// DIV=3 with parity, and DIV=1 without parity.
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] din;
  logic [2:0] vld;
  logic [2:0] s_o, busy_o, fd_o, rdy_o;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(4), .DIV(1), .PARITY_EN(1)) u_a (
    .clk(clk), .clr(clr), .din(din), .din_valid(vld[0]), .din_ready(rdy_o[0]),
    .s_out(s_o[0]), .busy(busy_o[0]), .frame_done(fd_o[0]));

  serial_word_tx #(.WIDTH(4), .DIV(3), .PARITY_EN(1)) u_b (
    .clk(clk), .clr(clr), .din(din), .din_valid(vld[1]), .din_ready(rdy_o[1]),
    .s_out(s_o[1]), .busy(busy_o[1]), .frame_done(fd_o[1]));

  serial_word_tx #(.WIDTH(4), .DIV(1), .PARITY_EN(0)) u_c (
    .clk(clk), .clr(clr), .din(din), .din_valid(vld[2]), .din_ready(rdy_o[2]),
    .s_out(s_o[2]), .busy(busy_o[2]), .frame_done(fd_o[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word on instance s from an idle cycle. bits[i] is the expected line
  // level of bit slot i (start first), each held div cycles. Returns in the
  // frame_done cycle. With keep set, din_valid stays high throughout.
  task automatic send(input int s, input logic [3:0] w, input logic [7:0] bits,
                      input int nb, input int div, input bit keep);
    din    = w;
    vld[s] = 1'b1;
    check("ready_before_accept", rdy_o[s], 1'b1);
    step();
    if (!keep) vld[s] = 1'b0;
    din = ~w;
    for (int k = 0; k < nb * div; k++) begin
      check($sformatf("s_out_i%0d_c%0d", s, k + 1), s_o[s], bits[k / div]);
      check($sformatf("busy_i%0d_c%0d", s, k + 1), busy_o[s], 1'b1);
      check($sformatf("fdone_i%0d_c%0d", s, k + 1), fd_o[s], 1'b0);
      check($sformatf("ready_i%0d_c%0d", s, k + 1), rdy_o[s], 1'b0);
      step();
    end
    check("fdone_pulse", fd_o[s], 1'b1);
    check("busy_after", busy_o[s], 1'b0);
    check("s_out_idle", s_o[s], 1'b1);
    check("ready_in_fdone", rdy_o[s], 1'b1);
  endtask

  task automatic after_frame(input int s);
    step();
    check("fdone_single", fd_o[s], 1'b0);
    check("s_out_rest", s_o[s], 1'b1);
  endtask

  initial begin
    clr = 1'b0;
    din = '0;
    vld = '0;
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      check("rst_s_out", s_o[s], 1'b1);
      check("rst_busy", busy_o[s], 1'b0);
      check("rst_fdone", fd_o[s], 1'b0);
      check("rst_ready", rdy_o[s], 1'b0);
    end
    clr = 1'b1;
    step();
    for (int s = 0; s < 3; s++) check("ready_after_rst", rdy_o[s], 1'b1);

    // 1010 -> 0,0,1,0,1,0,1
    send(0, 4'b1010, 8'h54, 7, 1, 1'b0);
    after_frame(0);
    // 0001 -> 0,1,0,0,0,1,1
    send(0, 4'b0001, 8'h62, 7, 1, 1'b0);
    after_frame(0);
    // DIV=3, 1010: line low cycles 1..6, frame_done in cycle 22
    send(1, 4'b1010, 8'h54, 7, 3, 1'b0);
    after_frame(1);
    // no parity, 0110 -> 0,0,1,1,0,1, frame_done in cycle 7
    send(2, 4'b0110, 8'h2C, 6, 1, 1'b0);
    after_frame(2);

    // Back-to-back with din_valid held: 1111 -> 0,1,1,1,1,0,1 then 0000 -> 0,0,0,0,0,0,1
    send(0, 4'b1111, 8'h5E, 7, 1, 1'b1);
    send(0, 4'b0000, 8'h40, 7, 1, 1'b0);
    after_frame(0);

    // Reset in the middle of a frame
    din    = 4'b1010;
    vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    check("mid_c1_start", s_o[0], 1'b0);
    step();
    step();
    check("mid_c3_busy", busy_o[0], 1'b1);
    clr = 1'b0;
    step();
    check("mid_rst_s_out", s_o[0], 1'b1);
    check("mid_rst_busy", busy_o[0], 1'b0);
    check("mid_rst_fdone", fd_o[0], 1'b0);
    check("mid_rst_ready", rdy_o[0], 1'b0);
    clr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("abort_no_fdone", fd_o[0], 1'b0);
      check("abort_idle_line", s_o[0], 1'b1);
      check("abort_ready", rdy_o[0], 1'b1);
    end
    send(0, 4'b0001, 8'h62, 7, 1, 1'b0);
    after_frame(0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
